// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the tx_arbiter slice.
// Bench helpers derive frame timing from SFD_LEN and DATA_LEN.
package tx_arb_pkg;

  localparam int DATA_LEN_DEF = 8;
  localparam int SFD_LEN      = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_FREE = 2'd2
  } state_t;

  // Cycles from grant to done for a given payload width.
  function automatic int grant_to_done(input int data_len);
    return data_len + SFD_LEN + 3;
  endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// Requester and transmitter signals of tx_arbiter.
// master: the arbiter side; slave: requesters plus transmitter.
interface tx_arbiter_if
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_LEN = DATA_LEN_DEF
);

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*DATA_LEN-1:0] req_data;
  logic [NUM_REQ-1:0]          grant;
  logic [NUM_REQ-1:0]          done;
  logic                        err;
  logic                        busy;
  logic                        tr_free;
  logic                        tr_start;
  logic [DATA_LEN-1:0]         din;

  modport master (
    input  req, req_data, tr_free,
    output grant, done, err, busy, tr_start, din
  );

  modport slave (
    output req, req_data, tr_free,
    input  grant, done, err, busy, tr_start, din
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin winner search starting one past the last served requester.
// Combinational; returns one-hot winner, its index and any-request flag.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [IW-1:0] p;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    p      = last;
    for (int k = 0; k < NUM_REQ; k++) begin
      p = (p == IW'(NUM_REQ - 1)) ? '0 : p + IW'(1);
      if (!any && req[p]) begin
        any       = 1'b1;
        idx       = p;
        onehot[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin sharing of one serial frame transmitter among NUM_REQ requesters.
// Define TX_ARB_WATCHDOG_EN to abort stalled transactions after WD_LIMIT cycles.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int WD_LIMIT = 64
) (
  input  logic         clk,
  input  logic         reset,
  tx_arbiter_if.master bus
);

  localparam int IW = $clog2(NUM_REQ);

  state_t               state;
  logic [IW-1:0]        last;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 err_q;
  logic                 start_q;
  logic [DATA_LEN-1:0]  din_q;

  logic [NUM_REQ-1:0]   win_oh;
  logic [IW-1:0]        win_idx;
  logic                 win_any;
  logic                 wd_hit;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req    (bus.req),
    .last   (last),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

`ifdef TX_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;

  // Zero on the first WAIT_BUSY cycle, counting through both wait states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wd_cnt <= '0;
    else if (state == IDLE)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 16'd1;
  end

  assign wd_hit = (wd_cnt == 16'(WD_LIMIT - 1));
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      last    <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      din_q   <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          // tr_free guard keeps a post-reset start off a running frame.
          if (bus.tr_free && win_any) begin
            grant_q <= win_oh;
            din_q   <= bus.req_data[win_idx*DATA_LEN +: DATA_LEN];
            start_q <= 1'b1;
            last    <= win_idx;
            state   <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!bus.tr_free) begin
            state <= WAIT_FREE;
          end else if (wd_hit) begin
            err_q   <= 1'b1;
            grant_q <= '0;
            state   <= IDLE;
          end
        end
        WAIT_FREE: begin
          if (bus.tr_free) begin
            done_q  <= grant_q;
            grant_q <= '0;
            state   <= IDLE;
          end else if (wd_hit) begin
            err_q   <= 1'b1;
            grant_q <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state != IDLE);
  assign bus.tr_start = start_q;
  assign bus.din      = din_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Randomized bench for tx_arbiter with a frame-level transmitter model.
// Expected winners come from a rotation model over the request vector.
module tb_tx_arbiter;
  import tx_arb_pkg::*;

  localparam int N   = 4;
  localparam int DL  = 8;
  localparam int WD  = 64;
  localparam int LAT = grant_to_done(DL);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tx_arbiter_if #(.NUM_REQ(N), .DATA_LEN(DL)) bus ();

  tx_arbiter #(
    .NUM_REQ  (N),
    .DATA_LEN (DL),
    .WD_LIMIT (WD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int m_last = N - 1;

  // Transmitter: tr_free low for SFD + data + 1 cycles after a start.
  int xcnt  = 0;
  bit stuck = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.tr_start && xcnt == 0 && !stuck)
      xcnt <= SFD_LEN + DL + 1;
    else if (xcnt > 0)
      xcnt <= xcnt - 1;
  end
  assign bus.tr_free = (xcnt == 0);

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (last + k) % N;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  bit prev_start = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_start <= 1'b0;
    end else begin
      chk("start_pulse", 64'(prev_start & bus.tr_start), 64'd0);
      chk("done_grant", 64'(|(bus.done & bus.grant)), 64'd0);
`ifndef TX_ARB_WATCHDOG_EN
      chk("err_zero", 64'(bus.err), 64'd0);
`endif
      prev_start <= bus.tr_start;
    end
  end

  task automatic wait_grant(input string tag, output int w,
                            output logic [DL-1:0] d);
    int n;
    n = 0;
    while (!(bus.busy == 1'b0 && bus.tr_free && bus.req != '0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start_to"}, 64'(n < 100), 64'd1);
    w = pick(bus.req, m_last);
    if (w < 0) w = 0;
    d = bus.req_data[w*DL +: DL];
    @(negedge clk);
    chk({tag, "_grant"}, 64'(bus.grant), 64'd1 << w);
    chk({tag, "_start"}, 64'(bus.tr_start), 64'd1);
    chk({tag, "_din"}, 64'(bus.din), 64'(d));
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    m_last = w;
  endtask

  task automatic wait_done(input string tag, input int w,
                           input logic [DL-1:0] d, input bit drop,
                           output int dcyc);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.req_data = $urandom;
      if (drop && lat == 4) bus.req[w] = 1'b0;
      if (bus.done == '0 && lat < LAT)
        chk({tag, "_hold"}, 64'(bus.grant), 64'd1 << w);
    end while (bus.done == '0 && lat < LAT + 10);
    dcyc = cyc;
    chk({tag, "_lat"}, 64'(lat), 64'(LAT));
    chk({tag, "_done"}, 64'(bus.done), 64'd1 << w);
    chk({tag, "_gclr"}, 64'(bus.grant), 64'd0);
    chk({tag, "_dinkeep"}, 64'(bus.din), 64'(d));
  endtask

  task automatic do_txn(input string tag, input bit drop, output int dcyc);
    int w;
    logic [DL-1:0] d;
    wait_grant(tag, w, d);
    wait_done(tag, w, d, drop, dcyc);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_grant"}, 64'(bus.grant), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_err"}, 64'(bus.err), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_start"}, 64'(bus.tr_start), 64'd0);
    chk({tag, "_din"}, 64'(bus.din), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_idle("rst");
    @(negedge clk);
    reset = 1'b1;
    m_last = N - 1;
  endtask

  initial begin
    int dc, prev_dc, w, n;
    logic [DL-1:0] d;

    bus.req      = '0;
    bus.req_data = '0;
    repeat (3) @(negedge clk);
    check_idle("por");
    reset = 1'b1;

    bus.req      = 4'b0100;
    bus.req_data = 32'h00A5_0000;
    do_txn("single", 1'b0, dc);
    bus.req = '0;

    do_reset();
    bus.req = 4'b1111;
    prev_dc = 0;
    for (int i = 0; i < 5; i++) begin
      do_txn("rr", 1'b0, dc);
      if (i > 0) chk("rr_gap", 64'(dc - prev_dc), 64'(LAT + 1));
      prev_dc = dc;
    end

    bus.req = 4'b0010;
    do_txn("drop", 1'b1, dc);
    chk("drop_req", 64'(bus.req), 64'd0);

    for (int i = 0; i < 20; i++) begin
      bus.req      = N'($urandom_range(1, (1 << N) - 1));
      bus.req_data = $urandom;
      do_txn("rand", 1'($urandom_range(0, 1)), dc);
    end

    bus.req = 4'b0011;
    wait_grant("mid", w, d);
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_idle("mid_rst");
    @(negedge clk);
    reset  = 1'b1;
    m_last = N - 1;
    n = 0;
    while (!bus.tr_free && n < 40) begin
      chk("mid_nostart", 64'(bus.tr_start), 64'd0);
      @(negedge clk);
      n++;
    end
    chk("mid_free_to", 64'(n < 40), 64'd1);
    do_txn("after_rst", 1'b0, dc);

    bus.req = 4'b1111;
    stuck   = 1'b1;
    wait_grant("stuck", w, d);
`ifdef TX_ARB_WATCHDOG_EN
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.err == 1'b0) chk("wd_nodone", 64'(bus.done), 64'd0);
    end while (bus.err == 1'b0 && n < 200);
    chk("wd_lat", 64'(n), 64'(WD));
    chk("wd_grant", 64'(bus.grant), 64'd0);
    chk("wd_done", 64'(bus.done), 64'd0);
    chk("wd_busy", 64'(bus.busy), 64'd0);
    stuck = 1'b0;
    do_txn("wd_next", 1'b0, dc);
`else
    repeat (200) @(negedge clk);
    chk("stuck_busy", 64'(bus.busy), 64'd1);
    chk("stuck_err", 64'(bus.err), 64'd0);
    chk("stuck_grant", 64'(bus.grant), 64'd1 << w);
    chk("stuck_done", 64'(bus.done), 64'd0);
    stuck = 1'b0;
    do_reset();
    do_txn("post_stuck", 1'b0, dc);
`endif

    bus.req = '0;
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin controller that shares one serial frame transmitter (8-bit SFD plus DATA_LEN data bits, `tr_start`/`tr_free` handshake) among NUM_REQ requesters. It sits between the requesters and the transmitter. It picks one requester, registers that requester's byte, and issues a single-cycle `tr_start`. It then follows `tr_free` through the frame and returns a per-requester `done` pulse.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `DATA_LEN`, 8: payload width; must match the transmitter's `data_len`
- `WD_LIMIT`, 64: watchdog limit in cycles; used only with `TX_ARB_WATCHDOG_EN`
- `clk` in 1: single clock; all logic on its rising edge
- `reset` in 1: asynchronous, active-low; asserts immediately, releases synchronously into IDLE
- `req` in NUM_REQ: level request, one bit per requester
- `req_data` in NUM_REQ*DATA_LEN: requester i's byte at bits [i*DATA_LEN +: DATA_LEN]
- `grant` out NUM_REQ: one-hot, held for the whole transaction
- `done` out NUM_REQ: one-cycle pulse to the granted requester when its frame completes
- `err` out 1: one-cycle watchdog abort pulse; tied 0 without the macro
- `busy` out 1: high in any state other than IDLE
- `tr_free` in 1: from the transmitter; high means the transmitter is idle
- `tr_start` out 1: to the transmitter; single-cycle pulse
- `din` out DATA_LEN: to the transmitter; registered copy of the granted requester's byte

## Operation
- Reset values: `grant`=0, `done`=0, `err`=0, `busy`=0, `tr_start`=0, `din`=0, state=IDLE, round-robin pointer `last`=NUM_REQ-1 (requester 0 wins first).
- States and transitions:
  - IDLE: if `tr_free`=1 and any `req` is set, pick winner w = first set bit searching from `last`+1 with wrap. Register `grant`=onehot(w), `din`=req_data[w], `tr_start`=1, `last`=w, then go to WAIT_BUSY. If `tr_free`=0 (transmitter still busy, e.g. after a mid-frame reset), stay in IDLE.
  - WAIT_BUSY: clear `tr_start` unconditionally. When `tr_free`=0, go to WAIT_FREE.
  - WAIT_FREE: when `tr_free`=1, register `done`=onehot(w) and `grant`=0, then go to IDLE.
- `req` dropped during a transaction: ignored; the frame completes and `done` still pulses.
- The requester may change `req_data` after `grant` rises, because `din` is already registered.
- Simultaneous requests: strict rotation. The requester just served has the lowest priority at the next decision.
- Reset asserted mid-frame: outputs clear immediately and the transaction is lost, with no `done`. The transmitter finishes its frame on its own, and the IDLE guard on `tr_free` prevents an overlapping start.

## Timing
- Cycle 0: IDLE sees `req` with `tr_free`=1.
- Cycle 1: `grant`, `din` and `tr_start` are high; the transmitter samples them.
- Cycle 2: `tr_free`=0.
- Cycles 2–9: SFD bits on the line.
- Cycles 10–17: data bits on the line.
- Cycle 19: `tr_free`=1.
- Cycle 20: `done` pulse, `grant`=0, state IDLE. The next `tr_start` can be at cycle 21.
- Grant-to-done latency is 19 cycles for DATA_LEN=8 (general: DATA_LEN+11).
- `tr_start` is never high for more than one consecutive cycle. `done` and `grant` are never high in the same cycle.

## Configuration
- `TX_ARB_WATCHDOG_EN` defined:
  - A 16-bit counter clears on entry to WAIT_BUSY and increments in WAIT_BUSY and WAIT_FREE.
  - If it reaches WD_LIMIT-1 before the exit condition: one-cycle `err` pulse, `grant`=0, no `done`, return to IDLE. `last` has already advanced, so the next requester is served first.
- `TX_ARB_WATCHDOG_EN` undefined: no counter; waits indefinitely; `err` is constant 0.

## Structure
- Shared package `tx_arb_pkg`:
  - State encoding localparams: IDLE=0, WAIT_BUSY=1, WAIT_FREE=2.
  - Default DATA_LEN and SFD length (8), used to derive frame length for benches.
- Sub-module `rr_priority_picker`: combinational. Inputs are `req` and `last`; outputs are the one-hot winner, the winner index and `any`. It is parameterised by NUM_REQ.

## Test plan
- Single request: `req`=4'b0100, `req_data[2]`=8'hA5 → `grant`=4'b0100 and `tr_start` at cycle 1, `din`=8'hA5, `done`=4'b0100 at cycle 20, line shows 11010101 (SFD) then A5 LSB-first.
- All four requesting continuously → grant order 0,1,2,3,0 with done pulses 20 cycles apart.
- Requester 1 drops `req` at cycle 5 → frame still completes, `done[1]` pulses at cycle 20.
- Reset pulsed low at cycle 8, with `tr_free` held low by the model until cycle 19 → all outputs 0 at once, no `tr_start` before cycle 20, then normal service resumes.
- Watchdog build, WD_LIMIT=64, transmitter model never drops `tr_free` → `err` pulses 64 cycles after `tr_start`, no `done`, next requester granted.
- Non-watchdog build with the same stuck model → remains in WAIT_BUSY, `busy`=1, `err`=0 indefinitely.
